pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard, flush and drain controller for the 5-stage core (IF, Dec, Exec, Mem, WB). It tracks a valid bit per stage and detects RAW hazards. It drives forwarding selects for operand A and B at Dec, generates stall, bubble and flush enables for the pipeline registers, and sequences halt so that `halt` asserts only after the pipeline drains. A mode parameter selects full forwarding or stall-only interlock. Saturating counters expose stall and flush activity.

Parameters:
REG_ADDR_W, 5, register index width
FWD_EN, 1, 1 = forwarding plus load-use stall; 0 = stall on any RAW until the producer leaves WB
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
dec_rs1, dec_rs2  in  REG_ADDR_W  source indices of the Dec instruction
dec_use_rs1, dec_use_rs2  in  1  Dec instruction reads rs1/rs2
ex_rd, mem_rd, wb_rd  in  REG_ADDR_W  destination index per stage
ex_wen, mem_wen, wb_wen  in  1  register write enable per stage
ex_is_load  in  1  Exec instruction is a load
br_taken_m  in  1  taken branch/jump resolved in Mem (npc_control)
halt_if  in  1  IF holds a halt instruction
pc_en  out  1  IF PC/fetch advance
dec_en  out  1  IF/Dec register load enable
kill_d, kill_e, kill_m  out  1  load NOP (valid=0) into Dec/Exec/Mem register this edge
v_d, v_e, v_m, v_w  out  1  stage valid bits
fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 Exec ALU result, 10 Mem result (ALU or load data), 11 WB write data
halt  out  1  pipeline drained after halt, sticky
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (async, rstn=0): v_* = 0, state RUN, halt = 0, counters = 0.
- Producer match in stage X (E/M/W): v_X && X_wen && X_rd != 0 && ((dec_use_rs1 && dec_rs1 == X_rd) || (dec_use_rs2 && dec_rs2 == X_rd)). Register x0 never matches.
- Hazard with FWD_EN=1: stall = v_d && E-match && ex_is_load.
- Hazard with FWD_EN=0: stall = v_d && (E-match || M-match || W-match). The regfile has no write-through.
- Forwarding with FWD_EN=1: per operand, the priority is E (01) > M (10) > W (11) > regfile (00). Each operand is evaluated independently. Selects are 00 when v_d = 0. With FWD_EN=0, selects are always 00.
- Flush: flush = br_taken_m && v_m. Flush has priority over stall and halt.
- Combinational outputs:
  - On flush: kill_d = kill_e = kill_m = 1, pc_en = 1, dec_en = 1.
  - On stall (no flush): pc_en = 0, dec_en = 0, kill_e = 1, kill_d = kill_m = 0.
  - Otherwise: pc_en = (state == RUN) && !halt_if, dec_en = 1, kill_* = 0.
- Valid update on each clock edge:
  - v_w <= v_m
  - v_m <= v_e && !flush
  - v_e <= v_d && !stall && !flush
  - v_d <= flush ? 0 : stall ? v_d : (state == RUN && !halt_if)
  - A halt instruction is never marked valid in Dec.
- State machine:
  - RUN -> DRAIN when halt_if && !stall && !flush.
  - DRAIN -> RUN on flush. An older branch cancels the halt; PC redirects and fetch resumes.
  - DRAIN -> HALTED when v_d, v_e, v_m and v_w are all 0 and there is no flush.
  - HALTED is terminal until reset. halt = 1 only in HALTED and is registered.
  - In DRAIN and HALTED, pc_en = 0 except on flush.
- Counters:
  - stall_cnt increments on each cycle with stall && !flush.
  - flush_cnt increments on each flush cycle.
  - Both saturate at 2^CNT_W - 1 and never wrap.
- Simultaneous events:
  - flush + stall: flush wins and no stall is counted.
  - flush + halt_if: no DRAIN entry.
  - Reset mid-DRAIN returns to RUN with all valid bits cleared.

Test Plan:
1. Reset then 4 independent ALU ops (no matches) -> v_d..v_w fill one per cycle; pc_en = 1 throughout; fwd selects 00; counters stay 0.
2. FWD_EN=1: add x5 in Exec, Dec reads x5 on rs1 -> fwd_a_sel = 01. The next cycle with add in Mem -> 10. The cycle after -> 11. Any producer with rd = x0 -> 00.
3. FWD_EN=1: lw x6 in Exec, Dec uses rs2 = x6 -> exactly one cycle with pc_en = 0, dec_en = 0, kill_e = 1; the next cycle fwd_b_sel = 10; stall_cnt = 1.
4. Taken branch in Mem while a load-use stall is also present -> kill_d = kill_e = kill_m = 1, v_d = v_e = v_m = 0 next cycle, v_w = 1; flush_cnt = 1, stall_cnt unchanged.
5. halt_if with 3 valid instructions in flight -> DRAIN, pc_en = 0; halt rises on the cycle after v_w clears and stays high. A variant with br_taken_m during DRAIN returns to RUN and halt stays 0.
6. FWD_EN=0, CNT_W=2: dependent add directly after its producer -> 3 stall cycles with bubbles; stall_cnt saturates at 3 and does not wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/flush/drain controller.
// The slave modport is the controller's view; the master is the core datapath side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2;
  logic                  dec_use_rs1, dec_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
  logic                  ex_wen, mem_wen, wb_wen;
  logic                  ex_is_load;
  logic                  br_taken_m;
  logic                  halt_if;
  logic                  pc_en, dec_en;
  logic                  kill_d, kill_e, kill_m;
  logic                  v_d, v_e, v_m, v_w;
  logic [1:0]            fwd_a_sel, fwd_b_sel;
  logic                  halt;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  modport master (
    output dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           ex_rd, mem_rd, wb_rd, ex_wen, mem_wen, wb_wen,
           ex_is_load, br_taken_m, halt_if,
    input  pc_en, dec_en, kill_d, kill_e, kill_m,
           v_d, v_e, v_m, v_w, fwd_a_sel, fwd_b_sel,
           halt, stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           ex_rd, mem_rd, wb_rd, ex_wen, mem_wen, wb_wen,
           ex_is_load, br_taken_m, halt_if,
    output pc_en, dec_en, kill_d, kill_e, kill_m,
           v_d, v_e, v_m, v_w, fwd_a_sel, fwd_b_sel,
           halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding, flush and halt-drain control for the 5-stage core.
// state | meaning: RUN = normal fetch | DRAIN = halt seen, emptying pipe | HALTED = drained, terminal
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic                   clk,
  input logic                   rstn,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q;
  logic             v_d_q, v_e_q, v_m_q, v_w_q;
  logic             halt_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic a_e, a_m, a_w, b_e, b_m, b_w;
  logic stall, flush;
  logic pc_en, dec_en, kill_d, kill_e, kill_m;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  // x0 is hardwired zero, so a write to it is never a real producer
  assign a_e = v_e_q && bus.ex_wen  && (bus.ex_rd  != '0) && bus.dec_use_rs1 && (bus.dec_rs1 == bus.ex_rd);
  assign a_m = v_m_q && bus.mem_wen && (bus.mem_rd != '0) && bus.dec_use_rs1 && (bus.dec_rs1 == bus.mem_rd);
  assign a_w = v_w_q && bus.wb_wen  && (bus.wb_rd  != '0) && bus.dec_use_rs1 && (bus.dec_rs1 == bus.wb_rd);
  assign b_e = v_e_q && bus.ex_wen  && (bus.ex_rd  != '0) && bus.dec_use_rs2 && (bus.dec_rs2 == bus.ex_rd);
  assign b_m = v_m_q && bus.mem_wen && (bus.mem_rd != '0) && bus.dec_use_rs2 && (bus.dec_rs2 == bus.mem_rd);
  assign b_w = v_w_q && bus.wb_wen  && (bus.wb_rd  != '0) && bus.dec_use_rs2 && (bus.dec_rs2 == bus.wb_rd);

  assign stall = FWD_EN ? (v_d_q && (a_e || b_e) && bus.ex_is_load)
                        : (v_d_q && (a_e || a_m || a_w || b_e || b_m || b_w));
  assign flush = bus.br_taken_m && v_m_q;

  function automatic logic [1:0] fwd_sel(input logic e, input logic m, input logic w);
    if (e)      return 2'b01;
    else if (m) return 2'b10;
    else if (w) return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (FWD_EN && v_d_q) begin
      fwd_a_sel = fwd_sel(a_e, a_m, a_w);
      fwd_b_sel = fwd_sel(b_e, b_m, b_w);
    end
  end

  always_comb begin
    pc_en  = (state_q == RUN) && !bus.halt_if;
    dec_en = 1'b1;
    kill_d = 1'b0;
    kill_e = 1'b0;
    kill_m = 1'b0;
    if (flush) begin
      pc_en  = 1'b1;
      kill_d = 1'b1;
      kill_e = 1'b1;
      kill_m = 1'b1;
    end else if (stall) begin
      pc_en  = 1'b0;
      dec_en = 1'b0;
      kill_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      v_d_q   <= 1'b0;
      v_e_q   <= 1'b0;
      v_m_q   <= 1'b0;
      v_w_q   <= 1'b0;
    end else begin
      v_w_q <= v_m_q;
      v_m_q <= v_e_q && !flush;
      v_e_q <= v_d_q && !stall && !flush;
      // the halt instruction itself never enters Dec as valid
      v_d_q <= flush ? 1'b0 : (stall ? v_d_q : ((state_q == RUN) && !bus.halt_if));
      case (state_q)
        RUN:
          if (bus.halt_if && !stall && !flush) state_q <= DRAIN;
        DRAIN:
          if (flush) begin
            state_q <= RUN;
          end else if (!(v_d_q || v_e_q || v_m_q || v_w_q)) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
          end
        HALTED: ;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !flush && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1))           flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.dec_en    = dec_en;
  assign bus.kill_d    = kill_d;
  assign bus.kill_e    = kill_e;
  assign bus.kill_m    = kill_m;
  assign bus.v_d       = v_d_q;
  assign bus.v_e       = v_e_q;
  assign bus.v_m       = v_m_q;
  assign bus.v_w       = v_w_q;
  assign bus.fwd_a_sel = fwd_a_sel;
  assign bus.fwd_b_sel = fwd_b_sel;
  assign bus.halt      = halt_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: forwarding controller (FWD_EN=1) and interlock-only controller (FWD_EN=0, CNT_W=2).
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus_f ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  bus_s ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (.clk(clk), .rstn(rstn), .bus(bus_f));
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(2))  u_stl (.clk(clk), .rstn(rstn), .bus(bus_s));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_f(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] erd, input logic ewen, input logic eld,
                       input logic [4:0] mrd, input logic mwen, input logic [4:0] wrd, input logic wwen,
                       input logic br, input logic hlt);
    bus_f.dec_rs1 = rs1; bus_f.dec_use_rs1 = u1;
    bus_f.dec_rs2 = rs2; bus_f.dec_use_rs2 = u2;
    bus_f.ex_rd = erd;   bus_f.ex_wen = ewen; bus_f.ex_is_load = eld;
    bus_f.mem_rd = mrd;  bus_f.mem_wen = mwen;
    bus_f.wb_rd = wrd;   bus_f.wb_wen = wwen;
    bus_f.br_taken_m = br; bus_f.halt_if = hlt;
    #1;
  endtask

  task automatic idle_f(input logic hlt);
    drv_f(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, hlt);
  endtask

  task automatic drv_s(input logic [4:0] rs1, input logic u1, input logic [4:0] erd, input logic ewen,
                       input logic [4:0] mrd, input logic mwen, input logic [4:0] wrd, input logic wwen);
    bus_s.dec_rs1 = rs1; bus_s.dec_use_rs1 = u1;
    bus_s.dec_rs2 = 5'd0; bus_s.dec_use_rs2 = 1'b0;
    bus_s.ex_rd = erd;   bus_s.ex_wen = ewen; bus_s.ex_is_load = 1'b0;
    bus_s.mem_rd = mrd;  bus_s.mem_wen = mwen;
    bus_s.wb_rd = wrd;   bus_s.wb_wen = wwen;
    bus_s.br_taken_m = 1'b0; bus_s.halt_if = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] vf();
    return {bus_f.v_d, bus_f.v_e, bus_f.v_m, bus_f.v_w};
  endfunction

  function automatic logic [3:0] vs();
    return {bus_s.v_d, bus_s.v_e, bus_s.v_m, bus_s.v_w};
  endfunction

  initial begin
    logic [3:0] fill [4];
    fill = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};

    idle_f(1'b0);
    drv_s(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #10;
    check("rst_v",        vf(), 4'b0000);
    check("rst_halt",     bus_f.halt, 1'b0);
    check("rst_stallcnt", bus_f.stall_cnt, 0);
    check("rst_flushcnt", bus_f.flush_cnt, 0);
    rstn = 1'b1;
    #1;
    check("t1_pc_en0", bus_f.pc_en, 1'b1);

    // 1: independent ALU ops fill the pipe one stage per cycle
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t1_v",     vf(), fill[i]);
      check("t1_pc_en", bus_f.pc_en, 1'b1);
      check("t1_fwd",   {bus_f.fwd_a_sel, bus_f.fwd_b_sel}, 4'b0000);
    end
    check("t1_stallcnt", bus_f.stall_cnt, 0);
    check("t1_flushcnt", bus_f.flush_cnt, 0);

    // 2: forwarding priorities
    drv_f(5'd5, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("t2_fwd_e",   bus_f.fwd_a_sel, 2'b01);
    check("t2_fwd_b00", bus_f.fwd_b_sel, 2'b00);
    check("t2_nostall", bus_f.pc_en, 1'b1);
    tick;
    drv_f(5'd5, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("t2_fwd_m", bus_f.fwd_a_sel, 2'b10);
    tick;
    drv_f(5'd5, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    check("t2_fwd_w", bus_f.fwd_a_sel, 2'b11);
    drv_f(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    check("t2_x0", {bus_f.fwd_a_sel, bus_f.fwd_b_sel}, 4'b0000);
    drv_f(5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    check("t2_prio_indep", {bus_f.fwd_a_sel, bus_f.fwd_b_sel}, 4'b0110);
    drv_f(5'd5, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check("t2_unused_rs1", {bus_f.fwd_a_sel, bus_f.fwd_b_sel}, 4'b0011);

    // 3: load-use stall for one cycle, then forward from Mem
    drv_f(5'd1, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("t3_ctl", {bus_f.pc_en, bus_f.dec_en, bus_f.kill_d, bus_f.kill_e, bus_f.kill_m}, 5'b00010);
    tick;
    drv_f(5'd1, 1'b1, 5'd6, 1'b1, 5'd3, 1'b0, 1'b0, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("t3_v",        vf(), 4'b1011);
    check("t3_pc_en",    bus_f.pc_en, 1'b1);
    check("t3_fwd_b",    bus_f.fwd_b_sel, 2'b10);
    check("t3_stallcnt", bus_f.stall_cnt, 1);
    idle_f(1'b0);
    tick;
    tick;
    check("t3_v_refill", vf(), 4'b1110);

    // 4: flush wins over a simultaneous load-use stall
    drv_f(5'd1, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    check("t4_ctl", {bus_f.pc_en, bus_f.dec_en, bus_f.kill_d, bus_f.kill_e, bus_f.kill_m}, 5'b11111);
    tick;
    idle_f(1'b0);
    check("t4_v",        vf(), 4'b0001);
    check("t4_flushcnt", bus_f.flush_cnt, 1);
    check("t4_stallcnt", bus_f.stall_cnt, 1);

    // 5: halt with three instructions in flight drains, then sticks
    tick;
    tick;
    tick;
    check("t5_v_pre", vf(), 4'b1110);
    idle_f(1'b1);
    check("t5_pc_en_hif", bus_f.pc_en, 1'b0);
    tick;
    check("t5_v_a", vf(), 4'b0111);
    check("t5_pc_en_drain", bus_f.pc_en, 1'b0);
    tick;
    check("t5_v_b", vf(), 4'b0011);
    tick;
    check("t5_v_c", vf(), 4'b0001);
    check("t5_halt_c", bus_f.halt, 1'b0);
    tick;
    check("t5_v_d", vf(), 4'b0000);
    check("t5_halt_d", bus_f.halt, 1'b0);
    tick;
    check("t5_halt_rise", bus_f.halt, 1'b1);
    idle_f(1'b0);
    check("t5_pc_en_halted", bus_f.pc_en, 1'b0);
    tick;
    tick;
    check("t5_halt_sticky", bus_f.halt, 1'b1);
    check("t5_v_halted", vf(), 4'b0000);

    // 5b: branch resolved during DRAIN cancels the halt
    rstn = 1'b0;
    #1;
    check("t5b_rst_v",    vf(), 4'b0000);
    check("t5b_rst_halt", bus_f.halt, 1'b0);
    #1;
    rstn = 1'b1;
    tick;
    tick;
    tick;
    check("t5b_v_pre", vf(), 4'b1110);
    idle_f(1'b1);
    tick;
    idle_f(1'b0);
    check("t5b_v_drain", vf(), 4'b0111);
    check("t5b_pc_en_drain", bus_f.pc_en, 1'b0);
    drv_f(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    check("t5b_flush_ctl", {bus_f.pc_en, bus_f.kill_m}, 2'b11);
    tick;
    idle_f(1'b0);
    check("t5b_v_flush", vf(), 4'b0001);
    check("t5b_pc_en_run", bus_f.pc_en, 1'b1);
    tick;
    check("t5b_v_d", bus_f.v_d, 1'b1);
    tick;
    tick;
    tick;
    check("t5b_halt_low", bus_f.halt, 1'b0);
    check("t5b_flushcnt", bus_f.flush_cnt, 1);

    // 6: interlock-only: dependent add right after producer stalls 3 cycles
    check("t6_v_pre",     vs(), 4'b1111);
    check("t6_cnt_pre",   bus_s.stall_cnt, 0);
    drv_s(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    check("t6_ctl_e", {bus_s.pc_en, bus_s.dec_en, bus_s.kill_e}, 3'b001);
    check("t6_fwd",   bus_s.fwd_a_sel, 2'b00);
    tick;
    drv_s(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    check("t6_v_bubble", bus_s.v_e, 1'b0);
    check("t6_pc_en_m",  bus_s.pc_en, 1'b0);
    check("t6_cnt1",     bus_s.stall_cnt, 1);
    tick;
    drv_s(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    check("t6_pc_en_w", bus_s.pc_en, 1'b0);
    check("t6_cnt2",    bus_s.stall_cnt, 2);
    tick;
    drv_s(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("t6_release", {bus_s.pc_en, bus_s.kill_e}, 2'b10);
    check("t6_cnt3",    bus_s.stall_cnt, 3);
    tick;
    drv_s(5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    check("t6_stall4", bus_s.pc_en, 1'b0);
    tick;
    drv_s(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("t6_sat", bus_s.stall_cnt, 3);
    tick;
    check("t6_sat_hold", bus_s.stall_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
